conv_feeder: RTL

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_feeder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/conv_feeder.sv
// conv_feeder: moves DDR read beats into the weight or feature buffer, one unit at a time.
// Each unit starts only after the selected buffer reports room for a whole unit.
// Optional build macro: CONV_FEEDER_STALL_CNT_EN adds the 32-bit stall_cnt output.
//
// state  | meaning
// IDLE   | waiting for a command (cmd_ready high when not finishing one)
// SETTLE | two-cycle wait so pending writes reach the full flags
// CHECK  | wait for the selected buffer to have room for one unit
// XFER   | accept exactly one unit of beats from the stream
module conv_feeder #(
  parameter int DATA_WIDTH      = 64,
  parameter int UNIT_BURSTS_WEI = 32,
  parameter int UNIT_BURSTS_FTM = 1024,
  parameter int B_UNITS         = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_type,
  input  logic [B_UNITS-1:0]    cmd_units,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wb_we,
  output logic                  fb_we,
  output logic [DATA_WIDTH-1:0] di,
  input  logic                  wb_full,
  input  logic                  fb_full,
  output logic                  done,
  output logic                  busy
`ifdef CONV_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int UNIT_MAX = (UNIT_BURSTS_WEI > UNIT_BURSTS_FTM) ? UNIT_BURSTS_WEI : UNIT_BURSTS_FTM;
  localparam int BW       = $clog2(UNIT_MAX) + 1;
  localparam logic [BW-1:0] LAST_WEI = BW'(UNIT_BURSTS_WEI - 1);
  localparam logic [BW-1:0] LAST_FTM = BW'(UNIT_BURSTS_FTM - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, XFER} state_e;

  state_e                state_q, state_d;
  logic                  settle_q, settle_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [B_UNITS-1:0]    unit_q, unit_d;
  logic [B_UNITS-1:0]    units_q, units_d;
  logic                  type_q, type_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  zpend_q, zpend_d;
  logic                  wb_we_q, wb_we_d;
  logic                  fb_we_q, fb_we_d;
  logic [DATA_WIDTH-1:0] di_q, di_d;
  logic                  rdy_en_q;

  logic                  accept;
  logic                  beat_ok;
  logic                  full_sel;
  logic                  last_beat;
  logic [B_UNITS-1:0]    unit_inc;

  assign cmd_ready = rdy_en_q & (state_q == IDLE) & ~busy_q;
  assign s_ready   = (state_q == XFER);
  assign accept    = cmd_valid & cmd_ready;
  assign beat_ok   = s_valid & s_ready;
  assign full_sel  = type_q ? fb_full : wb_full;
  assign last_beat = (beat_q == (type_q ? LAST_FTM : LAST_WEI));
  assign unit_inc  = unit_q + B_UNITS'(1);

  assign wb_we = wb_we_q;
  assign fb_we = fb_we_q;
  assign di    = di_q;
  assign done  = done_q;
  assign busy  = busy_q;

  // Holds cmd_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_en_q <= 1'b0;
    else       rdy_en_q <= 1'b1;
  end

  // Next-state, counters and registered write path.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    beat_d   = beat_q;
    unit_d   = unit_q;
    units_d  = units_q;
    type_d   = type_q;
    busy_d   = done_q ? 1'b0 : busy_q;
    done_d   = zpend_q;
    zpend_d  = 1'b0;
    wb_we_d  = 1'b0;
    fb_we_d  = 1'b0;
    di_d     = di_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          type_d  = cmd_type;
          units_d = cmd_units;
          busy_d  = 1'b1;
          beat_d  = '0;
          unit_d  = '0;
          if (cmd_units == '0) begin
            zpend_d = 1'b1;
          end else begin
            state_d  = SETTLE;
            settle_d = 1'b0;
          end
        end
      end
      SETTLE: begin
        settle_d = ~settle_q;
        if (settle_q) state_d = CHECK;
      end
      CHECK: begin
        if (!full_sel) state_d = XFER;
      end
      XFER: begin
        if (beat_ok) begin
          di_d    = s_data;
          wb_we_d = ~type_q;
          fb_we_d = type_q;
          if (last_beat) begin
            beat_d = '0;
            unit_d = unit_inc;
            if (unit_inc == units_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = SETTLE;
              settle_d = 1'b0;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      settle_q <= 1'b0;
      beat_q   <= '0;
      unit_q   <= '0;
      units_q  <= '0;
      type_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zpend_q  <= 1'b0;
      wb_we_q  <= 1'b0;
      fb_we_q  <= 1'b0;
      di_q     <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      beat_q   <= beat_d;
      unit_q   <= unit_d;
      units_q  <= units_d;
      type_q   <= type_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zpend_q  <= zpend_d;
      wb_we_q  <= wb_we_d;
      fb_we_q  <= fb_we_d;
      di_q     <= di_d;
    end
  end

`ifdef CONV_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  assign stall_cnt = stall_q;

  // Saturating count of cycles spent waiting for buffer room.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == CHECK) && full_sel && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule
